// File: rtl/f_btb_nextpc.sv
// f_btb_nextpc: fetch PC register with a direct-mapped, write-first BTB and saturating fetch/hit counters
module f_btb_nextpc #(
  parameter int PC_W  = 13,
  parameter int IDX_W = 11,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [PC_W-1:0]           redirect_pc,
  input  logic                      btb_wen,
  input  logic [IDX_W-1:0]          btb_waddr,
  input  logic [PC_W-IDX_W+PC_W:0]  btb_wdata,
  output logic [PC_W-1:0]           pc,
  output logic [PC_W-1:0]           pc_predicted,
  output logic                      btb_hit,
  output logic [CNT_W-1:0]          lookup_cnt,
  output logic [CNT_W-1:0]          hit_cnt
);
  localparam int TAG_W = PC_W - IDX_W;
  localparam int ENT_W = 1 + TAG_W + PC_W;
  logic [TAG_W+PC_W-1:0] mem [2**IDX_W];
  logic [2**IDX_W-1:0]   valid;
  logic [IDX_W-1:0]      idx;
  logic [ENT_W-1:0]      ent;
  assign idx = pc[IDX_W-1:0];
  // a same-cycle write to the looked-up index wins over stored contents
  always_comb begin
    ent = (btb_wen && btb_waddr == idx) ? btb_wdata : {valid[idx], mem[idx]};
    btb_hit = ent[ENT_W-1] && ent[ENT_W-2:PC_W] == pc[PC_W-1:IDX_W];
    pc_predicted = btb_hit ? ent[PC_W-1:0] : pc + PC_W'(1);
  end
  always_ff @(posedge clk)
    if (btb_wen && !rst) mem[btb_waddr] <= btb_wdata[ENT_W-2:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (btb_wen) valid[btb_waddr] <= btb_wdata[ENT_W-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= '0;
      lookup_cnt <= '0;
      hit_cnt <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pc_predicted;
      if (lookup_cnt != '1) lookup_cnt <= lookup_cnt + CNT_W'(1);
      if (btb_hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_f_btb_nextpc.sv
// tb_f_btb_nextpc: directed tests of fetch PC, BTB lookup/bypass, redirect priority and counters
module tb_f_btb_nextpc;
  logic        clk = 0, rst = 1, stall = 0, redirect = 0, btb_wen = 0;
  logic [12:0] redirect_pc = 0;
  logic [10:0] btb_waddr = 0;
  logic [15:0] btb_wdata = 0;
  logic [12:0] pc, pc_predicted;
  logic        btb_hit;
  logic [15:0] lookup_cnt, hit_cnt, lc, hc;
  int errors = 0, checks = 0;

  f_btb_nextpc dut (.clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .btb_wen(btb_wen), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
    .pc(pc), .pc_predicted(pc_predicted), .btb_hit(btb_hit), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [12:0] a);
    redirect = 1; redirect_pc = a;
    step();
    redirect = 0; stall = 1;
    #1;
  endtask

  task automatic btb_write(input logic [10:0] a, input logic [15:0] d);
    stall = 1; btb_wen = 1; btb_waddr = a; btb_wdata = d;
    step();
    btb_wen = 0;
    #1;
  endtask

  task automatic test_reset;
    step(); step();
    rst = 0;
    go_to(13'h0123);
    checks++; if (pc !== 13'h0123) begin errors++; $display("FAIL pre_reset_pc got=%h exp=0123", pc); end
    #2 rst = 1; #1;
    checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL async_rst_pc got=%h exp=0000", pc); end
    checks++; if (btb_hit !== 1'b0 || pc_predicted !== 13'h0001) begin errors++; $display("FAIL async_rst_pred got=%b/%h exp=0/0001", btb_hit, pc_predicted); end
    checks++; if (lookup_cnt !== 0 || hit_cnt !== 0) begin errors++; $display("FAIL async_rst_cnt got=%h/%h exp=0/0", lookup_cnt, hit_cnt); end
    stall = 0;
    step(); step();
    rst = 0;
    repeat (5) step();
    checks++; if (pc !== 13'd5) begin errors++; $display("FAIL run5_pc got=%h exp=0005", pc); end
    checks++; if (lookup_cnt !== 16'd5 || hit_cnt !== 16'd0) begin errors++; $display("FAIL run5_cnt got=%0d/%0d exp=5/0", lookup_cnt, hit_cnt); end
  endtask

  task automatic test_hit;
    btb_write(11'h010, 16'h8040);
    go_to(13'h0010);
    checks++; if (btb_hit !== 1'b1 || pc_predicted !== 13'h0040) begin errors++; $display("FAIL hit_lookup got=%b/%h exp=1/0040", btb_hit, pc_predicted); end
    stall = 0;
    step();
    stall = 1;
    checks++; if (pc !== 13'h0040) begin errors++; $display("FAIL hit_next_pc got=%h exp=0040", pc); end
    checks++; if (lookup_cnt !== 16'd6 || hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_cnt got=%0d/%0d exp=6/1", lookup_cnt, hit_cnt); end
  endtask

  task automatic test_alias_invalidate;
    go_to(13'h0810);
    checks++; if (btb_hit !== 1'b0 || pc_predicted !== 13'h0811) begin errors++; $display("FAIL alias got=%b/%h exp=0/0811", btb_hit, pc_predicted); end
    go_to(13'h0010);
    checks++; if (btb_hit !== 1'b1) begin errors++; $display("FAIL alias_untouched got=%b exp=1", btb_hit); end
    btb_write(11'h010, 16'h0000);
    checks++; if (btb_hit !== 1'b0 || pc_predicted !== 13'h0011) begin errors++; $display("FAIL invalidate got=%b/%h exp=0/0011", btb_hit, pc_predicted); end
  endtask

  task automatic test_bypass;
    go_to(13'h0020);
    stall = 0; btb_wen = 1; btb_waddr = 11'h020; btb_wdata = 16'h8100;
    #1;
    checks++; if (btb_hit !== 1'b1 || pc_predicted !== 13'h0100) begin errors++; $display("FAIL bypass got=%b/%h exp=1/0100", btb_hit, pc_predicted); end
    step();
    btb_wen = 0; stall = 1;
    #1;
    checks++; if (pc !== 13'h0100) begin errors++; $display("FAIL bypass_next_pc got=%h exp=0100", pc); end
    go_to(13'h0020);
    checks++; if (btb_hit !== 1'b1 || pc_predicted !== 13'h0100) begin errors++; $display("FAIL stored_after_bypass got=%b/%h exp=1/0100", btb_hit, pc_predicted); end
    btb_wen = 1; btb_waddr = 11'h020; btb_wdata = 16'h0100;
    #1;
    checks++; if (btb_hit !== 1'b0 || pc_predicted !== 13'h0021) begin errors++; $display("FAIL bypass_invalid got=%b/%h exp=0/0021", btb_hit, pc_predicted); end
    step();
    btb_wen = 0;
    #1;
  endtask

  task automatic test_redirect_stall;
    lc = lookup_cnt; hc = hit_cnt;
    stall = 1; redirect = 1; redirect_pc = 13'h0555;
    step();
    redirect = 0;
    checks++; if (pc !== 13'h0555) begin errors++; $display("FAIL redir_over_stall got=%h exp=0555", pc); end
    checks++; if (lookup_cnt !== lc || hit_cnt !== hc) begin errors++; $display("FAIL redir_cnt got=%0d/%0d exp=%0d/%0d", lookup_cnt, hit_cnt, lc, hc); end
    repeat (3) step();
    checks++; if (pc !== 13'h0555) begin errors++; $display("FAIL stall_hold got=%h exp=0555", pc); end
    checks++; if (lookup_cnt !== lc || hit_cnt !== hc) begin errors++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", lookup_cnt, hit_cnt, lc, hc); end
  endtask

  task automatic test_wrap_saturate;
    go_to(13'h1FFF);
    checks++; if (btb_hit !== 1'b0 || pc_predicted !== 13'h0000) begin errors++; $display("FAIL wrap_pred got=%b/%h exp=0/0000", btb_hit, pc_predicted); end
    stall = 0;
    step();
    checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    repeat (65540) step();
    checks++; if (lookup_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=FFFF", lookup_cnt); end
    step();
    checks++; if (lookup_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=FFFF", lookup_cnt); end
    stall = 1;
  endtask

  task automatic test_reset_drops_write;
    #2 rst = 1; btb_wen = 1; btb_waddr = 11'h030; btb_wdata = 16'h8200;
    step();
    btb_wen = 0; rst = 0;
    go_to(13'h0030);
    checks++; if (btb_hit !== 1'b0) begin errors++; $display("FAIL write_during_reset got=%b exp=0", btb_hit); end
    go_to(13'h0020);
    checks++; if (btb_hit !== 1'b0) begin errors++; $display("FAIL reset_clears_valid got=%b exp=0", btb_hit); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_alias_invalidate();
    test_bypass();
    test_redirect_stall();
    test_wrap_saturate();
    test_reset_drops_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
